// File: rtl/seri_alici.sv
// seri_alici: serial receive stage. Reassembles LSB-first BIT-bit frames from
// a qualified bit stream and buffers finished words in a small FWFT FIFO.
//
// Handshake: a bit is taken on every rising edge where gecerli_giris=1 (no
// back-pressure, the sender never waits); a word is popped on every rising
// edge where oku=1 and hazir=1, and oku while hazir=0 is ignored.
module seri_alici #(
    parameter int BIT     = 4,
    parameter int ADRES_W = 2
) (
    input  logic               saat,
    input  logic               reset,
    input  logic               bit_girisi,
    input  logic               gecerli_giris,
    input  logic               oku,
    output logic [BIT-1:0]     veri_cikisi,
    output logic               hazir,
    output logic               dolu,
    output logic [ADRES_W:0]   doluluk,
    output logic               cerceve_hatasi,
    output logic               tasma
);

    localparam int DERINLIK = 2 ** ADRES_W;
    localparam int SW       = $clog2(BIT);
    localparam logic [SW-1:0]    SON       = SW'(BIT - 1);
    localparam logic [ADRES_W:0] DOLU_SAYI = (ADRES_W + 1)'(DERINLIK);

    typedef enum logic {
        BOSTA = 1'b0,
        ALIM  = 1'b1
    } durum_t;

    // Receiver state (durum_q is the state a checker should bind to)
    durum_t          durum_q, durum_d;
    logic [SW-1:0]   sayac_q, sayac_d;
    logic [BIT-1:0]  kaydirma_q, kaydirma_d;
    logic            hata_q, hata_d;
    logic            yaz;
    logic [BIT-1:0]  yaz_veri;

    // FIFO state
    logic [BIT-1:0]     bellek_q [DERINLIK];
    logic [ADRES_W-1:0] yaz_ptr_q, oku_ptr_q;
    logic [ADRES_W:0]   sayi_q;
    logic               tasma_q;
    logic               bos_degil, tam, cek, it_kabul, tasma_olay;

    // Receiver next-state: collect bits, emit a push on the last bit of a frame
    always_comb begin
        durum_d    = durum_q;
        sayac_d    = sayac_q;
        kaydirma_d = kaydirma_q;
        hata_d     = 1'b0;
        yaz        = 1'b0;
        // The last bit goes straight into the word so it is pushed on its own edge
        yaz_veri   = {bit_girisi, kaydirma_q[BIT-2:0]};
        case (durum_q)
            BOSTA: begin
                if (gecerli_giris) begin
                    kaydirma_d[0] = bit_girisi;
                    sayac_d       = SW'(1);
                    durum_d       = ALIM;
                end
            end
            ALIM: begin
                if (gecerli_giris) begin
                    kaydirma_d[sayac_q] = bit_girisi;
                    if (sayac_q == SON) begin
                        yaz     = 1'b1;
                        sayac_d = '0;
                        durum_d = BOSTA;
                    end else begin
                        sayac_d = sayac_q + SW'(1);
                    end
                end else begin
                    // Qualifier dropped mid-frame: abandon it and flag a short frame
                    sayac_d = '0;
                    durum_d = BOSTA;
                    hata_d  = 1'b1;
                end
            end
            default: begin
                sayac_d = '0;
                durum_d = BOSTA;
            end
        endcase
    end

    // Receiver registers
    always_ff @(posedge saat) begin
        if (!reset) begin
            durum_q    <= BOSTA;
            sayac_q    <= '0;
            kaydirma_q <= '0;
            hata_q     <= 1'b0;
        end else begin
            durum_q    <= durum_d;
            sayac_q    <= sayac_d;
            kaydirma_q <= kaydirma_d;
            hata_q     <= hata_d;
        end
    end

    // A pop on a full FIFO frees the slot the simultaneous push needs
    assign bos_degil  = (sayi_q != '0);
    assign tam        = (sayi_q == DOLU_SAYI);
    assign cek        = oku && bos_degil;
    assign it_kabul   = yaz && (!tam || cek);
    assign tasma_olay = yaz && tam && !cek;

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge saat) begin
        if (!reset) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayi_q    <= '0;
            tasma_q   <= 1'b0;
        end else begin
            if (it_kabul) yaz_ptr_q <= yaz_ptr_q + ADRES_W'(1);
            if (cek)      oku_ptr_q <= oku_ptr_q + ADRES_W'(1);
            case ({it_kabul, cek})
                2'b10:   sayi_q <= sayi_q + (ADRES_W + 1)'(1);
                2'b01:   sayi_q <= sayi_q - (ADRES_W + 1)'(1);
                default: sayi_q <= sayi_q;
            endcase
            if (tasma_olay) tasma_q <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the count gates the output
    always_ff @(posedge saat) begin
        if (reset && it_kabul) bellek_q[yaz_ptr_q] <= yaz_veri;
    end

    assign hazir          = bos_degil;
    assign dolu           = tam;
    assign doluluk        = sayi_q;
    assign veri_cikisi    = bos_degil ? bellek_q[oku_ptr_q] : '0;
    assign cerceve_hatasi = hata_q;
    assign tasma          = tasma_q;

endmodule

// File: tb/tb_seri_alici.sv
// tb_seri_alici: directed scenarios plus random traffic, every cycle checked
// against a queue-based model of the receiver and FIFO.
module tb_seri_alici;

    localparam int BIT     = 4;
    localparam int ADRES_W = 2;
    localparam int DEPTH   = 2 ** ADRES_W;

    logic               saat;
    logic               reset;
    logic               bit_girisi;
    logic               gecerli_giris;
    logic               oku;
    logic [BIT-1:0]     veri_cikisi;
    logic               hazir;
    logic               dolu;
    logic [ADRES_W:0]   doluluk;
    logic               cerceve_hatasi;
    logic               tasma;

    int total;
    int bad;

    // Reference model state
    logic [BIT-1:0] exp_q[$];
    int             m_bits[$];
    logic           m_hata;
    logic           m_tasma;

    seri_alici #(.BIT(BIT), .ADRES_W(ADRES_W)) dut (
        .saat           (saat),
        .reset          (reset),
        .bit_girisi     (bit_girisi),
        .gecerli_giris  (gecerli_giris),
        .oku            (oku),
        .veri_cikisi    (veri_cikisi),
        .hazir          (hazir),
        .dolu           (dolu),
        .doluluk        (doluluk),
        .cerceve_hatasi (cerceve_hatasi),
        .tasma          (tasma)
    );

    // Clock
    initial saat = 1'b0;
    always #5 saat = ~saat;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Model one clock edge from the inputs about to be sampled
    task automatic model_edge(input logic v, input logic b, input logic o);
        int     w;
        logic   done;
        logic   pop;
        pop    = o && (exp_q.size() > 0);
        done   = 1'b0;
        m_hata = 1'b0;
        w      = 0;
        if (v) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == BIT) begin
                foreach (m_bits[i]) w = w + (m_bits[i] << i);
                done = 1'b1;
                m_bits.delete();
            end
        end else begin
            if (m_bits.size() > 0) m_hata = 1'b1;
            m_bits.delete();
        end
        if (pop) void'(exp_q.pop_front());
        if (done) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(BIT'(w));
            else m_tasma = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hazir"},   int'(hazir),          int'(exp_q.size() != 0));
        check({tag, ".dolu"},    int'(dolu),           int'(exp_q.size() == DEPTH));
        check({tag, ".doluluk"}, int'(doluluk),        exp_q.size());
        check({tag, ".veri"},    int'(veri_cikisi),    (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
        check({tag, ".hata"},    int'(cerceve_hatasi), int'(m_hata));
        check({tag, ".tasma"},   int'(tasma),          int'(m_tasma));
    endtask

    // One clock: drive at the falling edge, check 1ns after the rising edge
    task automatic step(input logic v, input logic b, input logic o, input string tag);
        gecerli_giris = v;
        bit_girisi    = b;
        oku           = o;
        model_edge(v, b, o);
        @(posedge saat);
        #1;
        check_all(tag);
        @(negedge saat);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            reset         = 1'b0;
            gecerli_giris = 1'($urandom_range(0, 1));
            bit_girisi    = 1'($urandom_range(0, 1));
            oku           = 1'($urandom_range(0, 1));
            exp_q.delete();
            m_bits.delete();
            m_hata  = 1'b0;
            m_tasma = 1'b0;
            @(posedge saat);
            #1;
            check_all("reset");
            @(negedge saat);
        end
        reset = 1'b1;
    endtask

    task automatic send_frame(input int val, input logic read_last, input string tag);
        logic [BIT-1:0] w;
        w = BIT'(val);
        for (int i = 0; i < BIT; i++)
            step(1'b1, w[i], (i == BIT - 1) ? read_last : 1'b0, tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        gecerli_giris = 1'b0;
        bit_girisi    = 1'b0;
        oku           = 1'b0;
        m_hata  = 1'b0;
        m_tasma = 1'b0;
        @(negedge saat);
        do_reset(2);

        // 1: single frame, then read it out
        send_frame(1, 1'b0, "t1");
        check("t1.veri_direct", int'(veri_cikisi), 1);
        step(1'b0, 1'b0, 1'b1, "t1.read");
        check("t1.hazir_after", int'(hazir), 0);

        // 2: two back-to-back frames with the qualifier held high
        send_frame(7, 1'b0, "t2");
        send_frame(12, 1'b0, "t2");
        check("t2.doluluk", int'(doluluk), 2);
        step(1'b0, 1'b0, 1'b1, "t2.read7");
        check("t2.second", int'(veri_cikisi), 12);
        step(1'b0, 1'b0, 1'b1, "t2.read12");

        // 3: short frame, then a good one
        step(1'b1, 1'b1, 1'b0, "t3");
        step(1'b1, 1'b1, 1'b0, "t3");
        step(1'b0, 1'b0, 1'b0, "t3.drop");
        check("t3.hata_pulse", int'(cerceve_hatasi), 1);
        step(1'b0, 1'b0, 1'b0, "t3.after");
        send_frame(12, 1'b0, "t3.good");
        check("t3.veri12", int'(veri_cikisi), 12);
        step(1'b0, 1'b0, 1'b1, "t3.read");

        // 4: overflow
        for (int k = 1; k <= 5; k++) send_frame(k, 1'b0, "t4");
        check("t4.tasma", int'(tasma), 1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, "t4.read");
        step(1'b0, 1'b0, 1'b0, "t4.idle");
        check("t4.tasma_sticky", int'(tasma), 1);

        // 5: push on full coinciding with a pop
        do_reset(1);
        for (int k = 1; k <= 4; k++) send_frame(k, 1'b0, "t5.fill");
        send_frame(9, 1'b1, "t5.pushpop");
        check("t5.doluluk", int'(doluluk), 4);
        check("t5.tasma", int'(tasma), 0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, "t5.read");

        // 6: reset mid-frame
        step(1'b1, 1'b1, 1'b0, "t6");
        step(1'b1, 1'b0, 1'b0, "t6");
        do_reset(1);
        send_frame(9, 1'b0, "t6.after");
        check("t6.veri9", int'(veri_cikisi), 9);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1);
            else step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seri_alici.md
Name: seri_alici

Overview:
- Downstream receive stage for the serial encryption unit.
- Consumes its LSB-first bit stream (bit_cikisi qualified by gecerli) and reassembles each BIT-bit frame into a parallel word.
- Buffers completed words in a small first-word-fall-through FIFO that the consumer drains with a read strobe.
- Flags short frames and FIFO overflow.

Parameters:
- BIT, 4, frame/word width in bits; must be >= 2.
- ADRES_W, 2, FIFO address width; DERINLIK = 2**ADRES_W words (default 4).

Ports:
- saat  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; the clock is named saat and the reset is named reset.
- bit_girisi  input  1  serial data bit, connected to the encryption unit's bit_cikisi.
- gecerli_giris  input  1  bit-valid qualifier, connected to the encryption unit's gecerli.
- oku  input  1  read strobe; pops the FIFO head when hazir=1.
- veri_cikisi  output  BIT  FIFO head word; valid only while hazir=1.
- hazir  output  1  FIFO not empty.
- dolu  output  1  FIFO full.
- doluluk  output  ADRES_W+1  number of stored words, 0..DERINLIK.
- cerceve_hatasi  output  1  one-cycle pulse when a frame ends early.
- tasma  output  1  sticky overflow flag.

Behaviour:
- Reset (reset==0 at a rising edge):
  - Discards any partial frame and empties the FIFO.
  - Clears the bit counter.
  - Output values: hazir=0, dolu=0, doluluk=0, cerceve_hatasi=0, tasma=0, veri_cikisi=0.
  - Reset overrides every other input in the same cycle, including mid-frame and mid-read.
- Receiver FSM, states BOSTA and ALIM; bit counter sayac, width enough for 0..BIT-1.
- BOSTA:
  - If gecerli_giris=1: shift register bit 0 <= bit_girisi, sayac=1, go to ALIM.
  - Otherwise stay in BOSTA.
- ALIM with gecerli_giris=1:
  - Store bit_girisi at position sayac.
  - If sayac==BIT-1, the word is complete: push {bit_girisi, stored bits} at this same edge, sayac=0, go to BOSTA.
  - Otherwise sayac+1.
- ALIM with gecerli_giris=0:
  - Discard the partial frame, sayac=0, go to BOSTA.
  - cerceve_hatasi=1 for exactly the following cycle.
- Back-to-back frames:
  - gecerli_giris may stay high across frames; bit BIT+1 starts the next frame with no gap.
  - BOSTA accepts it immediately.
- Latency: the completed word is visible on veri_cikisi, with hazir=1, immediately after the edge that sampled the last bit (no added cycle).
- FIFO:
  - First-word-fall-through; head word is always presented on veri_cikisi.
  - Pop occurs when oku=1 and hazir=1. oku while empty is ignored, with no state change.
  - Push and pop in the same cycle:
    - Both are performed when not empty; doluluk is unchanged.
    - When full, the pop frees a slot, so the push is accepted, no overflow occurs, and order is preserved.
    - When empty, the push succeeds and the ignored pop has no effect.
  - Push while full without a pop: the word is dropped and FIFO contents are unchanged. tasma=1 and stays 1 until reset.
  - Read and write pointers wrap modulo DERINLIK.
  - dolu = (doluluk==DERINLIK) and hazir = (doluluk!=0), both combinational from the count.

Test Plan:
1. Release reset after 2 cycles. Drive gecerli_giris=1 for 4 cycles with bits 1,0,0,0.
   -> After the 4th edge: hazir=1, veri_cikisi=1, doluluk=1. Pulse oku for 1 cycle -> hazir=0, doluluk=0.
2. Hold gecerli_giris=1 for 8 cycles with bits 1,1,1,0,0,0,1,1.
   -> doluluk=2, heads read out in order 7 then 12, cerceve_hatasi never asserted.
3. Drive gecerli_giris=1 for 2 cycles (bits 1,1), then 0.
   -> cerceve_hatasi high exactly 1 cycle, doluluk stays 0.
   Then send frame 0,0,1,1 -> veri_cikisi=12.
4. Send 5 frames of values 1,2,3,4,5 with no reads.
   -> dolu=1 after the 4th frame, 5th frame dropped, tasma=1.
   Four reads return 1,2,3,4. tasma remains 1 until reset.
5. With the FIFO full (1,2,3,4), complete frame 9 on the same edge as an oku pulse.
   -> doluluk stays 4, tasma=0, subsequent reads return 2,3,4,9.
6. Assert reset for 1 cycle after 2 bits of a frame.
   -> All outputs 0. A following frame 1,0,0,1 yields veri_cikisi=9.
